// File: rtl/jpeg2bmp_idct_mac_descale.sv
// IDCT multiply-accumulate tail: sums TERMS signed products, descales with round-half-up, narrows to OUT_WIDTH.
// Optional clamp-to-range narrowing is built when JPEG2BMP_MAC_SAT_EN is defined; otherwise the result wraps.
module jpeg2bmp_idct_mac_descale #(
   parameter int PROD_WIDTH = 41,
   parameter int TERMS      = 8,
   parameter int ACC_WIDTH  = 44,
   parameter int SHIFT      = 11,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PROD_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_sat,
   output logic                  err_len
);

   localparam int CNT_W = $clog2(TERMS);
   localparam int RW    = ACC_WIDTH + 1 - SHIFT;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERMS - 1);

   logic [CNT_W-1:0]     cnt;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] acc_base;
   logic [ACC_WIDTH-1:0] acc_next;
   logic [ACC_WIDTH-1:0] prod_ext;
   logic [ACC_WIDTH:0]   rnd;
   logic [ACC_WIDTH:0]   sum_rnd;
   logic [RW-1:0]        r_full;
   logic [OUT_WIDTH-1:0] r_narrow;
   logic                 r_sat;
   logic                 accept;
   logic                 at_last;
   logic                 close;
   logic                 xfer;
   logic                 unused_bits;

   assign in_ready = ce & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;
   assign at_last  = (cnt == CNT_LAST);
   assign close    = accept & (at_last | in_last);
   assign xfer     = ce & out_valid & out_ready;

   // First beat of a group starts from zero so acc never needs clearing on close.
   assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};
   assign acc_base = (cnt == '0) ? '0 : acc;
   assign acc_next = acc_base + prod_ext;

   always_comb begin
      rnd            = '0;
      rnd[SHIFT-1]   = 1'b1;
   end

   // One guard bit keeps the rounding add from overflowing; the slice is the arithmetic shift.
   assign sum_rnd = {acc_next[ACC_WIDTH-1], acc_next} + rnd;
   assign r_full  = sum_rnd[ACC_WIDTH:SHIFT];

`ifdef JPEG2BMP_MAC_SAT_EN
   logic ovf;

   // Out of range exactly when the bits above the output sign are not a pure sign extension.
   assign ovf = ~((&r_full[RW-1:OUT_WIDTH-1]) | ~(|r_full[RW-1:OUT_WIDTH-1]));

   always_comb begin
      r_narrow = r_full[OUT_WIDTH-1:0];
      r_sat    = 1'b0;
      if (ovf) begin
         r_sat    = 1'b1;
         r_narrow = r_full[RW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                 : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
   end

   assign unused_bits = ^sum_rnd[SHIFT-1:0];
`else
   assign r_narrow    = r_full[OUT_WIDTH-1:0];
   assign r_sat       = 1'b0;
   assign unused_bits = ^{sum_rnd[SHIFT-1:0], r_full[RW-1:OUT_WIDTH]};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         err_len   <= 1'b0;
      end else begin
         if (accept) begin
            acc <= acc_next;
            cnt <= close ? '0 : cnt + CNT_W'(1);
         end
         // Early last and missing last both reduce to last-flag disagreeing with the count.
         if (close && (in_last ^ at_last)) begin
            err_len <= 1'b1;
         end
         if (close) begin
            out_valid <= 1'b1;
            out_data  <= r_narrow;
            out_sat   <= r_sat;
         end else if (xfer) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
